i2c_master_arbiter: RTL and testbench

//  Shares one i2c master between NUM_REQ on-chip requesters. Each requester posts a one-byte

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_master_arbiter_rr_picker.sv | 42 ++++
 rtl/i2c_master_arbiter.sv | 154 +++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c master arbiter: master state codes,
// read/write encoding and the arbiter FSM state encoding.
package i2c_pkg;

    // State codes reported by the i2c master on its state port
    localparam logic [2:0] STATE_IDLE  = 3'd0;
    localparam logic [2:0] STATE_START = 3'd1;
    localparam logic [2:0] STATE_ADDR  = 3'd2;
    localparam logic [2:0] STATE_ACK   = 3'd3;
    localparam logic [2:0] STATE_DATA  = 3'd4;
    localparam logic [2:0] STATE_DONE  = 3'd5;

    // Direction encoding on the master rw port
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RUN,
        ARB_CAPTURE,
        ARB_ABORT,
        ARB_RECOVER
    } arb_state_e;

endpackage

// File: rtl/i2c_master_arbiter_rr_picker.sv
// Round-robin picker: scans req starting at ptr, wrapping modulo NUM_REQ,
// and reports the first set bit as index and one-hot winner.
module rr_picker
    import i2c_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx
);

    // Doubling the vector lets the wrapped scan use a plain increasing index
    logic [2*NUM_REQ-1:0] dbl;
    logic [IDX_W:0]       pos;

    assign dbl = {req, req};

    // First set request at or after ptr wins
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        pos    = '0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (!valid && dbl[pos]) begin
                valid = 1'b1;
                if (pos >= (IDX_W+1)'(NUM_REQ))
                    idx = IDX_W'(pos - (IDX_W+1)'(NUM_REQ));
                else
                    idx = pos[IDX_W-1:0];
            end
        end
        if (valid)
            winner = NUM_REQ'(1) << idx;
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c master between NUM_REQ requesters with round-robin
// arbitration. Each transaction releases the master from reset, waits for
// DONE (or a watchdog timeout), captures read data, then holds the master
// in reset for RECOVER_CYCLES before the next grant.
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic [7:0]           rdata,
    output logic                 m_rst,
    output logic                 m_rw,
    output logic [7:0]           m_data_in,
    input  logic [7:0]           m_data_out,
    input  logic [2:0]           m_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int REC_W = $clog2(RECOVER_CYCLES);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] oh_q, oh_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REC_W-1:0]   rec_q, rec_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               m_rw_q, m_rw_d;
    logic [7:0]         m_data_in_q, m_data_in_d;

    logic               pick_valid;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               sel_rw;
    logic [7:0]         sel_wdata;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_oh),
        .idx    (pick_idx)
    );

    // Select the winning requester's direction and write byte
    always_comb begin
        sel_rw    = 1'b0;
        sel_wdata = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_rw    = req_rw[i];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        state_d     = state_q;
        oh_d        = oh_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rec_d       = rec_q;
        rdata_d     = rdata_q;
        m_rw_d      = m_rw_q;
        m_data_in_d = m_data_in_q;
        case (state_q)
            ARB_IDLE: begin
                // Latch the command here so it is already stable during GRANT
                if (pick_valid) begin
                    state_d     = ARB_GRANT;
                    oh_d        = pick_oh;
                    ptr_d       = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
                    m_rw_d      = sel_rw;
                    m_data_in_d = sel_wdata;
                end
            end
            ARB_GRANT: begin
                cnt_d   = '0;
                state_d = ARB_RUN;
            end
            ARB_RUN: begin
                // DONE beats a simultaneous timeout; read data is taken while
                // the master still presents it, so rdata is valid with done
                if (m_state == STATE_DONE) begin
                    state_d = ARB_CAPTURE;
                    if (m_rw_q == RW_READ)
                        rdata_d = m_data_out;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                    state_d = ARB_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_CAPTURE, ARB_ABORT: begin
                rec_d   = '0;
                state_d = ARB_RECOVER;
            end
            ARB_RECOVER: begin
                if (rec_q == REC_W'(RECOVER_CYCLES-1))
                    state_d = ARB_IDLE;
                else
                    rec_d = rec_q + REC_W'(1);
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            oh_q        <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            rec_q       <= '0;
            rdata_q     <= 8'h00;
            m_rw_q      <= 1'b0;
            m_data_in_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            oh_q        <= oh_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rec_q       <= rec_d;
            rdata_q     <= rdata_d;
            m_rw_q      <= m_rw_d;
            m_data_in_q <= m_data_in_d;
        end
    end

    // Outputs decode from registered state, so reset takes effect at once
    assign gnt       = (state_q inside {ARB_GRANT, ARB_RUN, ARB_CAPTURE, ARB_ABORT}) ? oh_q : '0;
    assign done      = (state_q inside {ARB_CAPTURE, ARB_ABORT}) ? oh_q : '0;
    assign err       = (state_q == ARB_ABORT);
    assign m_rst     = (state_q != ARB_RUN);
    assign rdata     = rdata_q;
    assign m_rw      = m_rw_q;
    assign m_data_in = m_data_in_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with a simple master model that
// steps 0->1->2->4->5 once its reset is released.
module tb_i2c_master_arbiter;

    localparam int NR = 4;
    localparam int TO = 32;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req, req_rw, gnt, done;
    logic [8*NR-1:0] req_wdata;
    logic          err, m_rst, m_rw;
    logic [7:0]    rdata, m_data_in, m_data_out;
    logic [2:0]    m_state, model_state, force_state;
    logic          hang, force_en;
    logic [7:0]    model_rdata;
    int            step;
    int            passed = 0;
    int            total = 0;
    int            multi_gnt = 0;

    i2c_master_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .RECOVER_CYCLES(RC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .m_rst(m_rst), .m_rw(m_rw),
        .m_data_in(m_data_in), .m_data_out(m_data_out), .m_state(m_state)
    );

    always #5 clk = ~clk;

    // Master model: walks its state sequence while out of reset
    always_ff @(posedge clk) begin
        if (m_rst) step <= 0;
        else if (step < 4 && !(hang && step == 3)) step <= step + 1;
    end

    always_comb begin
        case (step)
            0: model_state = 3'd0;
            1: model_state = 3'd1;
            2: model_state = 3'd2;
            3: model_state = 3'd4;
            default: model_state = 3'd5;
        endcase
    end

    assign m_state    = force_en ? force_state : model_state;
    assign m_data_out = (m_state == 3'd5) ? model_rdata : 8'h00;

    always @(negedge clk) if ($countones(gnt) > 1) multi_gnt++;

    task automatic wait_gnt(output int c);
        c = 0;
        do begin @(negedge clk); c++; end while (gnt == '0 && c < 200);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        do begin @(negedge clk); c++; end while (done == '0 && c < 200);
    endtask

    task automatic test_reset;
        total++;
        if ({gnt, done, err, rdata, m_rst, m_rw, m_data_in} !== {4'b0, 4'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00})
            $display("FAIL reset_outputs got gnt=%b done=%b err=%b rdata=%h m_rst=%b m_rw=%b m_data_in=%h want 0,0,0,00,1,0,00",
                     gnt, done, err, rdata, m_rst, m_rw, m_data_in);
        else passed++;
    endtask

    task automatic test_write;
        int c;
        req_rw = 4'b0000; req_wdata[7:0] = 8'h3C; req = 4'b0001;
        wait_gnt(c);
        total++; if (gnt !== 4'b0001) $display("FAIL wr_gnt got %b want 0001", gnt); else passed++;
        total++; if (m_data_in !== 8'h3C) $display("FAIL wr_data got %h want 3c", m_data_in); else passed++;
        total++; if (m_rw !== 1'b0) $display("FAIL wr_rw got %b want 0", m_rw); else passed++;
        total++; if (m_rst !== 1'b1) $display("FAIL wr_mrst_grant got %b want 1", m_rst); else passed++;
        @(negedge clk);
        total++; if (m_rst !== 1'b0) $display("FAIL wr_mrst_run got %b want 0", m_rst); else passed++;
        wait_done(c);
        total++; if (c != 5) $display("FAIL wr_latency got %0d want 5", c); else passed++;
        total++; if (done !== 4'b0001) $display("FAIL wr_done got %b want 0001", done); else passed++;
        total++; if ({err, m_rst} !== 2'b01) $display("FAIL wr_err_mrst got %b want 01", {err, m_rst}); else passed++;
        req = 4'b0000;
        @(negedge clk);
        total++; if ({done, gnt} !== 8'h00) $display("FAIL wr_done_pulse got %b want 00000000", {done, gnt}); else passed++;
        repeat (RC) @(negedge clk);
    endtask

    task automatic test_read;
        int c;
        req_rw = 4'b0100; model_rdata = 8'hA5; req = 4'b0100;
        wait_gnt(c);
        total++; if ({gnt, m_rw} !== 5'b01001) $display("FAIL rd_gnt_rw got %b want 01001", {gnt, m_rw}); else passed++;
        wait_done(c);
        total++; if (done !== 4'b0100) $display("FAIL rd_done got %b want 0100", done); else passed++;
        total++; if (rdata !== 8'hA5) $display("FAIL rd_rdata got %h want a5", rdata); else passed++;
        total++; if (err !== 1'b0) $display("FAIL rd_err got %b want 0", err); else passed++;
        req = 4'b0000;
        repeat (RC+1) @(negedge clk);
    endtask

    task automatic test_contention;
        int c;
        logic [NR-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_rw = 4'b0000;
        // serve requester 3 alone so the pointer wraps to 0
        req = 4'b1000;
        wait_gnt(c);
        total++; if (gnt !== 4'b1000) $display("FAIL pre_gnt got %b want 1000", gnt); else passed++;
        wait_done(c);
        req = 4'b0000;
        repeat (RC+1) @(negedge clk);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(c);
            total++; if (gnt !== exp_g[i]) $display("FAIL cont_gnt%0d got %b want %b", i, gnt, exp_g[i]); else passed++;
            if (i > 0) begin
                total++; if (c != RC+2) $display("FAIL cont_spacing%0d got %0d want %0d", i, c, RC+2); else passed++;
            end
            wait_done(c);
            total++; if (done !== exp_g[i]) $display("FAIL cont_done%0d got %b want %b", i, done, exp_g[i]); else passed++;
            if (i == 4) req = 4'b0000;
        end
        total++; if (multi_gnt != 0) $display("FAIL cont_onehot got %0d multi-grant cycles want 0", multi_gnt); else passed++;
        repeat (RC+1) @(negedge clk);
    endtask

    task automatic test_wrap;
        int c;
        req = 4'b1000;
        wait_gnt(c);
        total++; if (gnt !== 4'b1000) $display("FAIL wrap_gnt3 got %b want 1000", gnt); else passed++;
        wait_done(c);
        req = 4'b0000;
        repeat (RC+1) @(negedge clk);
        req = 4'b1001;
        wait_gnt(c);
        total++; if (gnt !== 4'b0001) $display("FAIL wrap_gnt0 got %b want 0001", gnt); else passed++;
        wait_done(c);
        req = 4'b0000;
        repeat (RC+1) @(negedge clk);
    endtask

    task automatic test_timeout;
        int c;
        hang = 1'b1; model_rdata = 8'h5A; req_rw = 4'b0010; req = 4'b0010;
        wait_gnt(c);
        total++; if (gnt !== 4'b0010) $display("FAIL to_gnt got %b want 0010", gnt); else passed++;
        wait_done(c);
        total++; if (c != TO+1) $display("FAIL to_latency got %0d want %0d", c, TO+1); else passed++;
        total++; if ({done, err} !== 5'b00101) $display("FAIL to_done_err got %b want 00101", {done, err}); else passed++;
        total++; if (rdata !== 8'hA5) $display("FAIL to_rdata got %h want a5", rdata); else passed++;
        req = 4'b0000;
        @(negedge clk);
        total++; if ({gnt, err, m_rst} !== 6'b000001) $display("FAIL to_recover got %b want 000001", {gnt, err, m_rst}); else passed++;
        hang = 1'b0;
        repeat (RC) @(negedge clk);
    endtask

    task automatic test_done_vs_timeout;
        int c;
        int early = 0;
        force_en = 1'b1; force_state = 3'd7; model_rdata = 8'hC3; req_rw = 4'b0100; req = 4'b0100;
        wait_gnt(c);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (done != '0) early++;
            force_state = (k == TO) ? 3'd5 : ((k % 2) ? 3'd6 : 3'd3);
        end
        total++; if (early != 0) $display("FAIL edge_early got %0d done cycles want 0", early); else passed++;
        @(negedge clk);
        total++; if ({done, err} !== 5'b01000) $display("FAIL edge_done_err got %b want 01000", {done, err}); else passed++;
        total++; if (rdata !== 8'hC3) $display("FAIL edge_rdata got %h want c3", rdata); else passed++;
        force_en = 1'b0; req = 4'b0000;
        repeat (RC+1) @(negedge clk);
    endtask

    task automatic test_async_reset;
        int c;
        int spur = 0;
        req_rw = 4'b0000; req_wdata[15:8] = 8'h77; req = 4'b0001;
        wait_gnt(c);
        @(negedge clk);
        total++; if (m_rst !== 1'b0) $display("FAIL ar_run got m_rst=%b want 0", m_rst); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if ({gnt, m_rst, done} !== 9'b000010000) $display("FAIL ar_immediate got %b want 000010000", {gnt, m_rst, done}); else passed++;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin @(negedge clk); if (done != '0) spur++; end
        total++; if (spur != 0) $display("FAIL ar_no_done got %0d want 0", spur); else passed++;
        req = 4'b0010;
        wait_gnt(c);
        total++; if ({gnt, m_data_in} !== {4'b0010, 8'h77}) $display("FAIL ar_gnt got %b/%h want 0010/77", gnt, m_data_in); else passed++;
        wait_done(c);
        total++; if ({done, err} !== 5'b00100) $display("FAIL ar_done got %b want 00100", {done, err}); else passed++;
        req = 4'b0000;
        repeat (RC+1) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; req = '0; req_rw = '0; req_wdata = '0;
        hang = 1'b0; force_en = 1'b0; force_state = 3'd0; model_rdata = 8'h00;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b1;
        @(negedge clk);
        test_write;
        test_read;
        test_contention;
        test_wrap;
        test_timeout;
        test_done_vs_timeout;
        test_async_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
